// File: rtl/vcxo_meas_scheduler.sv
// Measurement sequencer for the gated VCXO frequency counter: clear/gate/stop/read over a
// level req/ack handshake, then error evaluation, clamped PWM update, lock and timeout tracking.
module vcxo_meas_scheduler #(
  parameter int unsigned GATE_CYCLES   = 1228800,
  parameter int unsigned NOMINAL_COUNT = 12288000,
  parameter int unsigned PWM_INIT      = 16000,
  parameter int unsigned PWM_MAX       = 32000,
  parameter int unsigned COARSE_TH     = 10,
  parameter int unsigned FINE_TH       = 1,
  parameter int unsigned LOCK_TH       = 1,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned ACK_TIMEOUT   = 65535
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        tx_in,
  input  logic [15:0] correction_in,
  output logic        cnt_clr_out,
  output logic        cnt_run_out,
  input  logic        cnt_ack_in,
  input  logic [31:0] cnt_value_in,
  output logic [31:0] pwm_out,
  output logic [31:0] freq_error_out,
  output logic        meas_valid_out,
  output logic        locked_out,
  output logic        timeout_out
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);

  localparam logic [31:0]        GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [31:0]        ACK_LIMIT = 32'(ACK_TIMEOUT);
  localparam logic [31:0]        NOMINAL_V = 32'(NOMINAL_COUNT);
  localparam logic [31:0]        PWM_INIT_V = 32'(PWM_INIT);
  localparam logic [31:0]        PWM_MAX_V = 32'(PWM_MAX);
  localparam logic signed [33:0] PWM_MAX_S = 34'(PWM_MAX);
  localparam logic [32:0]        COARSE_V = 33'(COARSE_TH);
  localparam logic [32:0]        FINE_V = 33'(FINE_TH);
  localparam logic [32:0]        LOCK_V = 33'(LOCK_TH);
  localparam logic [LCW-1:0]     LOCK_MAX = LCW'(LOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CLR_REL,
    S_GATE,
    S_STOP,
    S_EVAL,
    S_UPDATE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      wait_q, wait_d;
  logic [31:0]      cnt_val_q, cnt_val_d;
  logic [31:0]      err_q, err_d;
  logic             stable_q, stable_d;
  logic [31:0]      prev_err_q, prev_err_d;
  logic             prev_valid_q, prev_valid_d;
  logic [31:0]      pwm_q, pwm_d;
  logic [31:0]      freq_err_q, freq_err_d;
  logic             meas_valid_q, meas_valid_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic [31:0]        err_calc;
  logic [32:0]        err_mag;
  logic signed [33:0] pwm_ext, err_ext, pwm_calc;
  logic [LCW-1:0]     lock_inc;
  logic               ack_expired;

  assign err_calc    = cnt_val_q - NOMINAL_V + {{16{correction_in[15]}}, correction_in};
  assign err_mag     = err_q[31] ? (33'd0 - {1'b1, err_q}) : {1'b0, err_q};
  assign pwm_ext     = $signed({{2{pwm_q[31]}}, pwm_q});
  assign err_ext     = $signed({{2{err_q[31]}}, err_q});
  assign lock_inc    = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
  assign ack_expired = (wait_q == ACK_LIMIT);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q + 32'd1;
    cnt_val_d    = cnt_val_q;
    err_d        = err_q;
    stable_d     = stable_q;
    prev_err_d   = prev_err_q;
    prev_valid_d = prev_valid_q;
    pwm_d        = pwm_q;
    freq_err_d   = freq_err_q;
    meas_valid_d = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    pwm_calc     = pwm_ext;

    if (tx_in) begin
      // Transmit freezes the loop outright; the next reading must re-qualify as stable.
      state_d      = S_IDLE;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (enable_in) state_d = S_CLEAR;
        S_CLEAR: begin
          if (cnt_ack_in) state_d = S_CLR_REL;
          else if (ack_expired) begin
            timeout_d    = 1'b1;
            prev_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_CLR_REL: begin
          if (!cnt_ack_in) state_d = S_GATE;
          else if (ack_expired) begin
            timeout_d    = 1'b1;
            prev_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_GATE: if (wait_q == GATE_LAST) state_d = S_STOP;
        S_STOP: begin
          if (cnt_ack_in) begin
            cnt_val_d = cnt_value_in;
            state_d   = S_EVAL;
          end else if (ack_expired) begin
            timeout_d    = 1'b1;
            prev_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_EVAL: begin
          err_d    = err_calc;
          stable_d = prev_valid_q && (err_calc == prev_err_q);
          state_d  = S_UPDATE;
        end
        S_UPDATE: begin
          if (stable_q) begin
            if (err_mag > COARSE_V) begin
              pwm_calc   = pwm_ext - (err_ext <<< 1);
              freq_err_d = err_q;
            end else if (err_mag > FINE_V) begin
              pwm_calc   = pwm_ext - err_ext;
              freq_err_d = err_q;
            end else begin
              freq_err_d = 32'd0;
            end
            if (pwm_calc < 34'sd1)          pwm_d = 32'd1;
            else if (pwm_calc > PWM_MAX_S)  pwm_d = PWM_MAX_V;
            else                            pwm_d = pwm_calc[31:0];
          end
          if (err_mag <= LOCK_V) begin
            lock_cnt_d = lock_inc;
            locked_d   = (lock_inc == LOCK_MAX);
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
          prev_err_d   = err_q;
          prev_valid_d = 1'b1;
          meas_valid_d = 1'b1;
          state_d      = enable_in ? S_CLEAR : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) wait_d = 32'd0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      wait_q       <= 32'd0;
      cnt_val_q    <= 32'd0;
      err_q        <= 32'd0;
      stable_q     <= 1'b0;
      prev_err_q   <= 32'd0;
      prev_valid_q <= 1'b0;
      pwm_q        <= PWM_INIT_V;
      freq_err_q   <= 32'd0;
      meas_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cnt_val_q    <= cnt_val_d;
      err_q        <= err_d;
      stable_q     <= stable_d;
      prev_err_q   <= prev_err_d;
      prev_valid_q <= prev_valid_d;
      pwm_q        <= pwm_d;
      freq_err_q   <= freq_err_d;
      meas_valid_q <= meas_valid_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cnt_clr_out    = (state_q == S_CLEAR);
  assign cnt_run_out    = (state_q == S_GATE);
  assign pwm_out        = pwm_q;
  assign freq_error_out = freq_err_q;
  assign meas_valid_out = meas_valid_q;
  assign locked_out     = locked_q;
  assign timeout_out    = timeout_q;

endmodule
